pci_initiator: RTL and testbench
================================

Name: pci_initiator

Overview:
- PCI bus-master (initiator) engine; the counterpart of the slave-side target decode logic.
- Accepts a local transfer request (address, direction, length) and arbitrates for the bus with REQ_n/GNT_n.
- Drives the address phase, then runs 1–16 data phases with IRDY_n/TRDY_n handshaking.
- Handles target disconnect (STOP_n) and master abort (no DEVSEL_n), then returns transfer status to local logic.

Parameters:
- DEVSEL_TIMEOUT, 5, clocks after the address phase to wait for DEVSEL_n before master abort.
- LEN_W, 4, width of the length field; phases = req_len+1 (max 16).

Ports:
- clk  input  1  bus clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  local request strobe; sampled only in IDLE.
- req_write  input  1  1 = memory write (CBE 0111), 0 = memory read (CBE 0110).
- req_addr  input  32  DWORD-aligned start address; [1:0] driven as 00.
- req_len  input  LEN_W  number of data phases minus 1.
- wr_data  input  32  current write word.
- wr_data_ack  output  1  1-clk pulse per completed write data phase.
- rd_data  output  32  captured read word.
- rd_data_valid  output  1  1-clk pulse per completed read data phase.
- busy  output  1  high from request acceptance until return to IDLE.
- done  output  1  1-clk pulse at end of transaction.
- status  output  2  00 ok, 01 target disconnect, 10 master abort; held until next acceptance.
- xfer_count  output  5  completed data phases; held until next acceptance.
- REQ_n  output  1  bus request.
- GNT_n  input  1  bus grant.
- FRAME_n_i / IRDY_n_i  input  1 each  sampled bus FRAME#/IRDY#, used for bus-idle detection.
- FRAME_n_o / IRDY_n_o  output  1 each  driven FRAME#/IRDY#.
- ctl_oe  output  1  output enable for FRAME#/IRDY#.
- TRDY_n, DEVSEL_n, STOP_n  input  1 each  target responses.
- AD_o  output  32  AD drive value.
- AD_i  input  32  AD sample.
- AD_oe  output  1  AD output enable.
- CBE_n  output  4  command / byte enables.
- CBE_oe  output  1  CBE output enable.

Behaviour:
- Reset (async, rst=1) → IDLE. Outputs in reset: REQ_n=1, FRAME_n_o=1, IRDY_n_o=1, all *_oe=0, AD_o=0, CBE_n=F, rd_data=0, pulses=0, busy=0, status=00, xfer_count=0.
- Reset mid-transfer: all drivers released on the same cycle; no done pulse.
- States: IDLE, ARB, ADDR, DATA, TURN.
- IDLE:
  - req_valid=1 → latch addr, cmd, and remaining count (req_len+1).
  - Clear xfer_count and status, set busy → ARB. REQ_n=0 from the next cycle.
- ARB: wait for GNT_n=0 && FRAME_n_i=1 && IRDY_n_i=1 (sampled) → ADDR.
- ADDR (1 clk):
  - FRAME_n_o=0, ctl_oe=1, AD_oe=1, AD_o=addr, CBE_oe=1, CBE_n=cmd.
  - REQ_n returns to 1; start DEVSEL counter → DATA.
- DATA, driven signals:
  - IRDY_n_o=0 and CBE_n=0000 on every cycle.
  - Write: AD_oe=1, AD_o=wr_data (combinational from input).
  - Read: AD_oe=0 (turnaround cycle is the first DATA cycle).
  - FRAME_n_o=0 while remaining>1; FRAME_n_o=1 when remaining==1 (last phase).
- DATA, phase completion:
  - A phase completes on a clock where IRDY_n_o=0 && TRDY_n=0.
  - On completion: xfer_count+1, remaining−1.
  - Write: pulse wr_data_ack; the source must present the next word on the following cycle.
  - Read: rd_data<=AD_i and pulse rd_data_valid.
  - Completion of the last phase → TURN with status 00.
- DEVSEL timeout: DEVSEL_n not seen low within DEVSEL_TIMEOUT clocks after ADDR → master abort.
  - Set FRAME_n_o=1 for one cycle with IRDY_n_o=0, then → TURN, status 10, xfer_count=0.
- STOP_n=0 sampled in DATA with DEVSEL_n=0:
  - The current phase completes only if TRDY_n=0 on that same clock.
  - If remaining>1 after that: FRAME_n_o=1 next cycle, IRDY_n_o held 0 until STOP_n samples high, then → TURN with status 01.
  - If the STOP coincides with the last phase, status stays 00.
- TURN (1 clk):
  - Drive FRAME_n_o=1 and IRDY_n_o=1 with ctl_oe=1, AD_oe=0, CBE_oe=0.
  - Pulse done, busy=0 → IDLE. ctl_oe=0 in IDLE.
- GNT_n withdrawn while in ARB: keep waiting. GNT_n withdrawn after ADDR: ignored; the transaction finishes.
- req_valid while busy: ignored.

Test Plan:
- Single write: addr 0x00000400, len 0, TRDY low 1st DATA cycle → one ADDR cycle CBE 0111, AD=wr_data 0xA5A5A5A5 with FRAME_n high/IRDY_n low same cycle, wr_data_ack ×1, done, status 00, xfer_count 1.
- 4-phase read: len 3, TRDY inserts 2 wait states on phase 2, AD_i = 1,2,3,4 → rd_data_valid ×4 with 1..4, FRAME_n_o rises on phase 4, AD_oe=0 throughout DATA, xfer_count 4.
- Master abort: DEVSEL_n held high → FRAME_n_o deasserts 6th clock after ADDR, done, status 10, xfer_count 0.
- Disconnect: 8-phase write, STOP_n and TRDY_n low on phase 3 → 3 acks, FRAME_n_o high next cycle, status 01, xfer_count 3.
- Arbitration: req_valid with GNT_n high 10 clocks, then low while FRAME_n_i low 2 clocks → REQ_n low from cycle 2, ADDR only after FRAME_n_i and IRDY_n_i both high.
- Reset mid-burst: rst=1 during phase 2 of a 4-phase read → all oe low and REQ_n=1 immediately, no done, IDLE after release.

Source files
------------

// File: rtl/pci_initiator.sv
// PCI bus-master engine: arbitrates for the bus, drives the address phase, runs 1-16 data phases
// with IRDY#/TRDY# handshaking, and handles target disconnect and master abort.
module pci_initiator #(
  parameter int unsigned DEVSEL_TIMEOUT = 5,
  parameter int unsigned LEN_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  output logic             wr_data_ack,
  output logic [31:0]      rd_data,
  output logic             rd_data_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [4:0]       xfer_count,
  output logic             REQ_n,
  input  logic             GNT_n,
  input  logic             FRAME_n_i,
  input  logic             IRDY_n_i,
  output logic             FRAME_n_o,
  output logic             IRDY_n_o,
  output logic             ctl_oe,
  input  logic             TRDY_n,
  input  logic             DEVSEL_n,
  input  logic             STOP_n,
  output logic [31:0]      AD_o,
  input  logic [31:0]      AD_i,
  output logic             AD_oe,
  output logic [3:0]       CBE_n,
  output logic             CBE_oe
);

  localparam int unsigned CntW = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [LEN_W:0] RemOne = (LEN_W + 1)'(1);

  typedef enum logic [2:0] {StIdle, StArb, StAddr, StData, StDisc, StAbort, StTurn} state_e;

  state_e            r_state;
  logic [31:0]       r_addr;
  logic              r_write;
  logic [LEN_W:0]    r_remain;
  logic [CntW-1:0]   r_dcnt;
  logic              r_dev_seen;
  logic [31:0]       r_ad;
  logic              r_wr_sel;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_status;
  logic [4:0]        r_xfer;
  logic              r_req_n;
  logic              r_frame_n;
  logic              r_irdy_n;
  logic              r_ctl_oe;
  logic              r_ad_oe;
  logic [3:0]        r_cbe_n;
  logic              r_cbe_oe;

  logic              w_complete;
  logic              w_stop;
  logic [LEN_W:0]    w_remain_nxt;
  logic              w_to_turn;

  assign w_complete   = (r_state == StData) && !TRDY_n;
  assign w_stop       = (r_state == StData) && !STOP_n && !DEVSEL_n;
  assign w_remain_nxt = w_complete ? r_remain - RemOne : r_remain;
  assign w_to_turn    = (w_complete && r_remain == RemOne) ||
                        (r_state == StDisc && STOP_n) || (r_state == StAbort);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_remain   <= '0;
      r_dcnt     <= '0;
      r_dev_seen <= 1'b0;
      r_ad       <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_status   <= 2'b00;
      r_xfer     <= '0;
      r_req_n    <= 1'b1;
      r_frame_n  <= 1'b1;
      r_irdy_n   <= 1'b1;
      r_ctl_oe   <= 1'b0;
      r_ad_oe    <= 1'b0;
      r_cbe_n    <= 4'hF;
      r_cbe_oe   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_ctl_oe <= 1'b0;
          if (req_valid) begin
            r_addr   <= req_addr & 32'hFFFF_FFFC;
            r_write  <= req_write;
            r_remain <= {1'b0, req_len} + RemOne;
            r_xfer   <= '0;
            r_status <= 2'b00;
            r_busy   <= 1'b1;
            r_req_n  <= 1'b0;
            r_state  <= StArb;
          end
        end
        StArb: begin
          if (!GNT_n && FRAME_n_i && IRDY_n_i) begin
            r_req_n   <= 1'b1;
            r_frame_n <= 1'b0;
            r_ctl_oe  <= 1'b1;
            r_ad_oe   <= 1'b1;
            r_ad      <= r_addr;
            r_cbe_oe  <= 1'b1;
            r_cbe_n   <= r_write ? 4'b0111 : 4'b0110;
            r_state   <= StAddr;
          end
        end
        StAddr: begin
          r_irdy_n   <= 1'b0;
          r_cbe_n    <= 4'b0000;
          r_ad_oe    <= r_write;
          r_wr_sel   <= r_write;
          r_frame_n  <= (r_remain == RemOne);
          r_dcnt     <= CntW'(1);
          r_dev_seen <= 1'b0;
          r_state    <= StData;
        end
        StData: begin
          if (!DEVSEL_n) r_dev_seen <= 1'b1;
          if (w_complete) begin
            r_xfer   <= r_xfer + 5'd1;
            r_remain <= w_remain_nxt;
            if (!r_write) begin
              r_rd_data  <= AD_i;
              r_rd_valid <= 1'b1;
            end
          end
          // Last-phase completion wins over STOP#, so status stays ok in that case.
          if (w_complete && r_remain == RemOne) begin
            r_state <= StData;
          end else if (w_stop) begin
            r_frame_n <= 1'b1;
            r_state   <= StDisc;
          end else if (!r_dev_seen && DEVSEL_n && r_dcnt == CntW'(DEVSEL_TIMEOUT)) begin
            r_frame_n <= 1'b1;
            r_state   <= StAbort;
          end else begin
            if (!r_dev_seen && r_dcnt != CntW'(DEVSEL_TIMEOUT)) r_dcnt <= r_dcnt + CntW'(1);
            r_frame_n <= (w_remain_nxt == RemOne);
          end
        end
        StDisc:  r_status <= 2'b01;
        StAbort: begin
          r_status <= 2'b10;
          r_xfer   <= '0;
        end
        StTurn: begin
          r_ctl_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      if (w_to_turn) begin
        r_frame_n <= 1'b1;
        r_irdy_n  <= 1'b1;
        r_ad_oe   <= 1'b0;
        r_cbe_oe  <= 1'b0;
        r_cbe_n   <= 4'hF;
        r_wr_sel  <= 1'b0;
        r_state   <= StTurn;
      end
    end
  end

  // Write data is forwarded straight from the source so it can advance on each ack.
  assign wr_data_ack   = w_complete && r_write;
  assign AD_o          = r_wr_sel ? wr_data : r_ad;
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign status        = r_status;
  assign xfer_count    = r_xfer;
  assign REQ_n         = r_req_n;
  assign FRAME_n_o     = r_frame_n;
  assign IRDY_n_o      = r_irdy_n;
  assign ctl_oe        = r_ctl_oe;
  assign AD_oe         = r_ad_oe;
  assign CBE_n         = r_cbe_n;
  assign CBE_oe        = r_cbe_oe;

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: write, burst read, master abort, disconnect,
// arbitration and mid-burst reset, each checked against hand-computed values.
module tb_pci_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] wr_data;
  logic        wr_data_ack;
  logic [31:0] rd_data;
  logic        rd_data_valid, busy, done;
  logic [1:0]  status;
  logic [4:0]  xfer_count;
  logic        REQ_n, GNT_n, FRAME_n_i, IRDY_n_i, FRAME_n_o, IRDY_n_o, ctl_oe;
  logic        TRDY_n, DEVSEL_n, STOP_n;
  logic [31:0] AD_o, AD_i;
  logic        AD_oe;
  logic [3:0]  CBE_n;
  logic        CBE_oe;

  int n_checks = 0;
  int n_errors = 0;

  pci_initiator #(.DEVSEL_TIMEOUT(5), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .wr_data(wr_data), .wr_data_ack(wr_data_ack), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .busy(busy), .done(done), .status(status),
    .xfer_count(xfer_count), .REQ_n(REQ_n), .GNT_n(GNT_n), .FRAME_n_i(FRAME_n_i),
    .IRDY_n_i(IRDY_n_i), .FRAME_n_o(FRAME_n_o), .IRDY_n_o(IRDY_n_o), .ctl_oe(ctl_oe),
    .TRDY_n(TRDY_n), .DEVSEL_n(DEVSEL_n), .STOP_n(STOP_n), .AD_o(AD_o), .AD_i(AD_i),
    .AD_oe(AD_oe), .CBE_n(CBE_n), .CBE_oe(CBE_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic wr, input logic [31:0] addr, input logic [3:0] len);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    tick();
    req_valid = 1'b0;
  endtask

  logic       rd_trdy  [7] = '{1, 0, 1, 1, 0, 0, 0};
  logic [2:0] rd_adi   [7] = '{0, 1, 0, 0, 2, 3, 4};
  logic       rd_frame [7] = '{0, 0, 0, 0, 0, 0, 1};
  logic       rd_vld   [7] = '{0, 0, 1, 0, 0, 1, 1};
  logic [2:0] rd_exp   [7] = '{0, 0, 1, 0, 0, 2, 3};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_data = '0; GNT_n = 1'b0; FRAME_n_i = 1'b1; IRDY_n_i = 1'b1;
    TRDY_n = 1'b1; DEVSEL_n = 1'b1; STOP_n = 1'b1; AD_i = '0;
    tick(); tick();
    chk("rst_req_n", REQ_n, 1); chk("rst_frame", FRAME_n_o, 1); chk("rst_irdy", IRDY_n_o, 1);
    chk("rst_oe", {ctl_oe, AD_oe, CBE_oe}, 0); chk("rst_ad", AD_o, 0); chk("rst_cbe", CBE_n, 4'hF);
    chk("rst_busy", busy, 0); chk("rst_status", status, 0); chk("rst_xfer", xfer_count, 0);
    rst = 1'b0;
    tick();

    // Single write
    wr_data = 32'hA5A5A5A5;
    start(1'b1, 32'h0000_0403, 4'd0);
    chk("w1_req", REQ_n, 0); chk("w1_busy", busy, 1); chk("w1_arb_oe", ctl_oe, 0);
    tick();
    chk("w1_addr_frame", FRAME_n_o, 0); chk("w1_addr_ad", AD_o, 32'h400);
    chk("w1_addr_cbe", CBE_n, 4'b0111); chk("w1_addr_oe", {ctl_oe, AD_oe, CBE_oe}, 3'b111);
    chk("w1_addr_req", REQ_n, 1);
    tick();
    TRDY_n = 1'b0; DEVSEL_n = 1'b0; #1;
    chk("w1_data_frame", FRAME_n_o, 1); chk("w1_data_irdy", IRDY_n_o, 0);
    chk("w1_data_ad", AD_o, 32'hA5A5A5A5); chk("w1_data_cbe", CBE_n, 0);
    chk("w1_ack", wr_data_ack, 1);
    tick();
    TRDY_n = 1'b1; DEVSEL_n = 1'b1; #1;
    chk("w1_turn_ctl", {FRAME_n_o, IRDY_n_o, ctl_oe, AD_oe, CBE_oe}, 5'b11100);
    chk("w1_turn_ack", wr_data_ack, 0);
    tick();
    chk("w1_done", done, 1); chk("w1_busy_end", busy, 0); chk("w1_status", status, 0);
    chk("w1_xfer", xfer_count, 1); chk("w1_idle_oe", ctl_oe, 0);
    tick();
    chk("w1_done_pulse", done, 0);

    // 4-phase read with two wait states on phase 2
    start(1'b0, 32'h0000_1000, 4'd3);
    tick();
    chk("r4_addr_cbe", CBE_n, 4'b0110);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("r4_frame%0d", i), FRAME_n_o, rd_frame[i]);
      chk($sformatf("r4_adoe%0d", i), AD_oe, 0);
      chk($sformatf("r4_vld%0d", i), rd_data_valid, rd_vld[i]);
      if (rd_vld[i]) chk($sformatf("r4_rd%0d", i), rd_data, rd_exp[i]);
      DEVSEL_n = 1'b0; TRDY_n = rd_trdy[i]; AD_i = 32'(rd_adi[i]);
    end
    tick();
    TRDY_n = 1'b1; DEVSEL_n = 1'b1;
    chk("r4_vld_last", rd_data_valid, 1); chk("r4_rd_last", rd_data, 4);
    tick();
    chk("r4_done", done, 1); chk("r4_xfer", xfer_count, 4); chk("r4_status", status, 0);

    // Master abort: DEVSEL# never asserted
    start(1'b1, 32'h0000_2000, 4'd1);
    tick();
    chk("ma_addr", FRAME_n_o, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("ma_frame%0d", i), FRAME_n_o, 0);
    end
    tick();
    chk("ma_frame6", FRAME_n_o, 1); chk("ma_irdy6", IRDY_n_o, 0);
    tick();
    chk("ma_turn_irdy", IRDY_n_o, 1);
    tick();
    chk("ma_done", done, 1); chk("ma_status", status, 2'b10); chk("ma_xfer", xfer_count, 0);

    // Target disconnect on phase 3 of an 8-phase write
    start(1'b1, 32'h0000_3000, 4'd7);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      wr_data = 32'h1000 + 32'(i); TRDY_n = 1'b0; DEVSEL_n = 1'b0; STOP_n = (i != 2); #1;
      chk($sformatf("dc_ad%0d", i), AD_o, 32'h1000 + 32'(i));
      chk($sformatf("dc_ack%0d", i), wr_data_ack, 1);
      chk($sformatf("dc_frame%0d", i), FRAME_n_o, 0);
    end
    tick();
    chk("dc_frame_hi", FRAME_n_o, 1); chk("dc_irdy_held", IRDY_n_o, 0);
    chk("dc_no_ack", wr_data_ack, 0);
    tick();
    chk("dc_irdy_held2", IRDY_n_o, 0);
    STOP_n = 1'b1; TRDY_n = 1'b1;
    tick();
    DEVSEL_n = 1'b1;
    chk("dc_turn", IRDY_n_o, 1);
    tick();
    chk("dc_done", done, 1); chk("dc_status", status, 2'b01); chk("dc_xfer", xfer_count, 3);

    // Arbitration: wait for grant, then for bus idle
    GNT_n = 1'b1;
    start(1'b0, 32'h0000_4000, 4'd0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("arb_req%0d", i), REQ_n, 0);
      chk($sformatf("arb_wait%0d", i), ctl_oe, 0);
      tick();
    end
    GNT_n = 1'b0; FRAME_n_i = 1'b0;
    tick(); chk("arb_busbusy1", ctl_oe, 0);
    tick(); chk("arb_busbusy2", ctl_oe, 0);
    FRAME_n_i = 1'b1; IRDY_n_i = 1'b0;
    tick(); chk("arb_irdybusy", ctl_oe, 0);
    IRDY_n_i = 1'b1;
    tick();
    chk("arb_addr", {ctl_oe, FRAME_n_o}, 2'b10);
    GNT_n = 1'b1;
    tick();
    TRDY_n = 1'b0; DEVSEL_n = 1'b0; AD_i = 32'hDEADBEEF;
    tick();
    TRDY_n = 1'b1; DEVSEL_n = 1'b1;
    chk("arb_rd", rd_data, 32'hDEADBEEF);
    tick();
    chk("arb_done", done, 1); chk("arb_xfer", xfer_count, 1);
    GNT_n = 1'b0;

    // Reset in the middle of a 4-phase read
    start(1'b0, 32'h0000_5000, 4'd3);
    tick();
    tick();
    TRDY_n = 1'b0; DEVSEL_n = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("mr_oe", {ctl_oe, AD_oe, CBE_oe}, 0); chk("mr_req", REQ_n, 1);
    chk("mr_frame", FRAME_n_o, 1); chk("mr_busy", busy, 0);
    TRDY_n = 1'b1; DEVSEL_n = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mr_nodone%0d", i), done, 0);
      chk($sformatf("mr_idle%0d", i), {busy, REQ_n}, 2'b01);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
